// File: rtl/lock_code_entry_if.sv
// Keypad/display bundle between the lock front panel and the code-entry block:
// four raw buttons in, entered code and lock status out.
interface lock_code_entry_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic        btn_enter;
  logic [19:0] big_bin;
  logic [1:0]  cursor;
  logic        unlocked;
  logic        alarm;
  logic [2:0]  fail_count;

  modport master (
    output btn_up, btn_down, btn_sel, btn_enter,
    input  big_bin, cursor, unlocked, alarm, fail_count
  );

  modport slave (
    input  btn_up, btn_down, btn_sel, btn_enter,
    output big_bin, cursor, unlocked, alarm, fail_count
  );
endinterface

// File: rtl/lock_code_entry.sv
// Keypad-side producer for the digital lock: conditions four buttons, edits a
// 4-digit code, checks it against CODE and drives unlock / alarm / lockout.
module lock_code_entry #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [19:0] CODE            = {5'd1, 5'd2, 5'd3, 5'd4},
  parameter int          MAX_FAILS       = 3,
  parameter int          LOCKOUT_CYCLES  = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  lock_code_entry_if.slave bus
);
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LT_W      = $clog2(LOCKOUT_CYCLES + 1);
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_ENTER = 3;

  logic [3:0] raw;
  logic [3:0] pulse;

  assign raw = {bus.btn_enter, bus.btn_sel, bus.btn_down, bus.btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_prev_reg;
      logic [DB_W-1:0] cnt_reg;

      // The counter only runs while the synchronized level disagrees with the
      // accepted level, so any return to the old level restarts the wait.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          cnt_reg        <= '0;
        end else begin
          sync1_reg      <= raw[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign pulse[gi] = level_reg & ~level_prev_reg;
    end
  endgenerate

  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  state_t          state_reg;
  logic [4:0]      digit_reg [4];
  logic [1:0]      cursor_reg;
  logic            unlocked_reg;
  logic            alarm_reg;
  logic [2:0]      fail_reg;
  logic [LT_W-1:0] timer_reg;
  logic [19:0]     code_entered;

  assign code_entered = {digit_reg[3], digit_reg[2], digit_reg[1], digit_reg[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ENTRY;
      cursor_reg   <= 2'd3;
      unlocked_reg <= 1'b0;
      alarm_reg    <= 1'b0;
      fail_reg     <= 3'd0;
      timer_reg    <= '0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 5'd0;
    end else begin
      case (state_reg)
        ENTRY: begin
          // Only the highest-priority pulse acts: enter > sel > up > down.
          if (pulse[BTN_ENTER]) begin
            state_reg <= CHECK;
          end else if (pulse[BTN_SEL]) begin
            cursor_reg <= cursor_reg - 2'd1;
          end else if (pulse[BTN_UP]) begin
            digit_reg[cursor_reg] <= (digit_reg[cursor_reg] == 5'd9) ? 5'd0
                                                                     : digit_reg[cursor_reg] + 5'd1;
          end else if (pulse[BTN_DOWN]) begin
            digit_reg[cursor_reg] <= (digit_reg[cursor_reg] == 5'd0) ? 5'd9
                                                                     : digit_reg[cursor_reg] - 5'd1;
          end
        end
        CHECK: begin
          if (code_entered == CODE) begin
            state_reg    <= OPEN;
            unlocked_reg <= 1'b1;
            fail_reg     <= 3'd0;
          end else if (fail_reg + 3'd1 == 3'(MAX_FAILS)) begin
            state_reg <= LOCKOUT;
            alarm_reg <= 1'b1;
            fail_reg  <= 3'(MAX_FAILS);
            timer_reg <= LT_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_reg  <= ENTRY;
            fail_reg   <= fail_reg + 3'd1;
            cursor_reg <= 2'd3;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 5'd0;
          end
        end
        OPEN: begin
          if (pulse[BTN_ENTER]) begin
            state_reg    <= ENTRY;
            unlocked_reg <= 1'b0;
            cursor_reg   <= 2'd3;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 5'd0;
          end
        end
        LOCKOUT: begin
          // Timer is loaded with LOCKOUT_CYCLES-1 so alarm stays high exactly LOCKOUT_CYCLES cycles.
          if (timer_reg == '0) begin
            state_reg  <= ENTRY;
            alarm_reg  <= 1'b0;
            fail_reg   <= 3'd0;
            cursor_reg <= 2'd3;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 5'd0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: state_reg <= ENTRY;
      endcase
    end
  end

  assign bus.big_bin    = code_entered;
  assign bus.cursor     = cursor_reg;
  assign bus.unlocked   = unlocked_reg;
  assign bus.alarm      = alarm_reg;
  assign bus.fail_count = fail_reg;
endmodule

// File: tb/tb_lock_code_entry.sv
// Randomized and directed bench for lock_code_entry, checked every cycle against
// a window-based debounce model and a digit-array model of the lock.
module tb_lock_code_entry;
  localparam int          D     = 4;
  localparam int          L     = 16;
  localparam int          MAXF  = 3;
  localparam logic [19:0] CODE  = {5'd1, 5'd2, 5'd3, 5'd4};
  localparam int          M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_LOCK = 3;
  localparam logic [3:0]  UP = 4'b0001, DOWN = 4'b0010, SEL = 4'b0100, ENTER = 4'b1000;

  logic clk;
  logic rst;
  lock_code_entry_if bus();

  lock_code_entry #(
    .DEBOUNCE_CYCLES(D),
    .CODE(CODE),
    .MAX_FAILS(MAXF),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [3:0] hist_q[$];
  bit         lvl_m [4];
  bit         pend_m[4];
  int         dig_m [4];
  int         code_digit[4] = '{4, 3, 2, 1};
  int         cur_m, mode_m, fails_m, lock_left;

  task automatic model_clear();
    for (int p = 0; p < 4; p++) dig_m[p] = 0;
    cur_m = 3;
  endtask

  task automatic model_reset();
    hist_q.delete();
    for (int b = 0; b < 4; b++) begin
      lvl_m[b]  = 0;
      pend_m[b] = 0;
    end
    model_clear();
    mode_m = M_ENTRY;
    fails_m = 0;
    lock_left = 0;
  endtask

  task automatic model_fsm();
    int  act;
    bit  ok;
    act = -1;
    if (pend_m[3]) act = 3;
    else if (pend_m[2]) act = 2;
    else if (pend_m[0]) act = 0;
    else if (pend_m[1]) act = 1;
    case (mode_m)
      M_ENTRY: begin
        if (act == 3) mode_m = M_CHECK;
        else if (act == 2) cur_m = (cur_m + 3) % 4;
        else if (act == 0) dig_m[cur_m] = (dig_m[cur_m] + 1) % 10;
        else if (act == 1) dig_m[cur_m] = (dig_m[cur_m] + 9) % 10;
      end
      M_CHECK: begin
        ok = 1;
        for (int p = 0; p < 4; p++) if (dig_m[p] != code_digit[p]) ok = 0;
        if (ok) begin
          mode_m = M_OPEN;
          fails_m = 0;
        end else if (fails_m + 1 >= MAXF) begin
          mode_m = M_LOCK;
          fails_m = MAXF;
          lock_left = L;
        end else begin
          fails_m++;
          model_clear();
          mode_m = M_ENTRY;
        end
      end
      M_OPEN: begin
        if (act == 3) begin
          model_clear();
          mode_m = M_ENTRY;
        end
      end
      default: begin
        lock_left--;
        if (lock_left == 0) begin
          model_clear();
          fails_m = 0;
          mode_m = M_ENTRY;
        end
      end
    endcase
  endtask

  // A button is accepted once its synchronized value (two samples old) has
  // disagreed with the accepted level for the last D samples in a row.
  task automatic model_buttons();
    bit all_diff;
    hist_q.push_back({bus.btn_enter, bus.btn_sel, bus.btn_down, bus.btn_up});
    if (hist_q.size() > D + 2) void'(hist_q.pop_front());
    for (int b = 0; b < 4; b++) begin
      pend_m[b] = 0;
      if (hist_q.size() == D + 2) begin
        all_diff = 1;
        for (int i = 0; i < D; i++) if (hist_q[i][b] == lvl_m[b]) all_diff = 0;
        if (all_diff) begin
          lvl_m[b]  = ~lvl_m[b];
          pend_m[b] = lvl_m[b];
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_fsm();
      model_buttons();
    end
  end

  // Per-cycle compare plus alarm-width measurement
  int alarm_run = 0;
  always @(negedge clk) begin
    logic [19:0] exp_bb;
    if (rst) alarm_run = 0;
    else begin
      exp_bb = '0;
      for (int p = 0; p < 4; p++) exp_bb[5*p +: 5] = 5'(dig_m[p]);
      check("big_bin", bus.big_bin, exp_bb);
      check("cursor", bus.cursor, cur_m);
      check("unlocked", bus.unlocked, mode_m == M_OPEN);
      check("alarm", bus.alarm, mode_m == M_LOCK);
      check("fail_count", bus.fail_count, fails_m);
      if (bus.alarm) alarm_run++;
      else if (alarm_run != 0) begin
        check("alarm_width", alarm_run, L);
        alarm_run = 0;
      end
    end
  end

  task automatic set_btns(input logic [3:0] mask);
    bus.btn_up    = mask[0];
    bus.btn_down  = mask[1];
    bus.btn_sel   = mask[2];
    bus.btn_enter = mask[3];
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    @(negedge clk);
    set_btns(mask);
    repeat (hold) @(negedge clk);
    set_btns(4'b0000);
    repeat (gap) @(negedge clk);
    $display("press mask=%b hold=%0d gap=%0d big_bin=%h cursor=%0d fails=%0d", mask, hold, gap,
             bus.big_bin, bus.cursor, bus.fail_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic enter_code(input int d3, input int d2, input int d1, input int d0);
    int dv[4];
    dv = '{d0, d1, d2, d3};
    for (int p = 3; p >= 0; p--) begin
      repeat (dv[p]) press(UP, 8, 8);
      press(SEL, 8, 8);
    end
  endtask

  task automatic wait_alarm(input logic level, input string name);
    int n;
    n = 0;
    while (bus.alarm !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.alarm, level);
  endtask

  initial begin
    int n;
    logic [3:0] mask;
    rst = 1'b1;
    set_btns(4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_big_bin", bus.big_bin, 20'h00000);
    check("reset_cursor", bus.cursor, 2'd3);
    check("reset_unlocked", bus.unlocked, 1'b0);
    check("reset_alarm", bus.alarm, 1'b0);
    check("reset_fail_count", bus.fail_count, 3'd0);

    // Three ups and one down on position 3
    repeat (3) press(UP, 8, 8);
    press(DOWN, 8, 8);
    check("t1_big_bin", bus.big_bin, 20'h10000);
    check("t1_cursor", bus.cursor, 2'd3);

    // Wrap-around on position 2 and a full cursor cycle
    press(SEL, 8, 8);
    check("t2_cursor", bus.cursor, 2'd2);
    press(DOWN, 8, 8);
    check("t2_down_wrap", bus.big_bin, 20'h12400);
    press(UP, 8, 8);
    check("t2_up_wrap", bus.big_bin, 20'h10000);
    repeat (3) press(SEL, 8, 8);
    check("t2_cursor_wrap", bus.cursor, 2'd3);

    // Correct code, with press-to-unlock latency measured in clock edges
    do_reset();
    enter_code(1, 2, 3, 4);
    check("t3_code", bus.big_bin, 20'h08864);
    @(negedge clk);
    bus.btn_enter = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.unlocked && n < 40);
    check("t3_unlock_latency", n, D + 4);
    check("t3_fail_count", bus.fail_count, 3'd0);
    @(negedge clk);
    bus.btn_enter = 1'b0;
    repeat (8) @(negedge clk);
    press(ENTER, 8, 8);
    check("t3_relock_unlocked", bus.unlocked, 1'b0);
    check("t3_relock_big_bin", bus.big_bin, 20'h00000);
    check("t3_relock_cursor", bus.cursor, 2'd3);

    // Three wrong submissions into lockout; a press during lockout is ignored
    press(UP, 8, 8);
    press(ENTER, 8, 8);
    check("t4_fail1", bus.fail_count, 3'd1);
    check("t4_clear1", bus.big_bin, 20'h00000);
    press(UP, 8, 8);
    press(ENTER, 8, 8);
    check("t4_fail2", bus.fail_count, 3'd2);
    check("t4_clear2", bus.big_bin, 20'h00000);
    press(ENTER, 8, 8);
    check("t4_alarm", bus.alarm, 1'b1);
    press(UP, 4, 2);
    wait_alarm(1'b0, "t4_alarm_release");
    @(negedge clk);
    check("t4_after_fail", bus.fail_count, 3'd0);
    check("t4_after_big_bin", bus.big_bin, 20'h00000);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold for 10
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.btn_up = 1'b1;
      @(negedge clk);
      @(negedge clk); bus.btn_up = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_single_increment", bus.big_bin, 20'h08000);

    // Simultaneous enter+up: only the check happens
    do_reset();
    enter_code(1, 2, 3, 4);
    press(ENTER | UP, 8, 8);
    check("t6_simul_unlocked", bus.unlocked, 1'b1);
    check("t6_simul_big_bin", bus.big_bin, 20'h08864);
    press(ENTER, 8, 8);

    // Randomized presses, including glitches, short gaps and combinations
    do_reset();
    for (int i = 0; i < 120; i++) begin
      mask = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) mask = mask | (4'b0001 << $urandom_range(0, 3));
      if (mask[3] && $urandom_range(0, 1) == 0) mask = UP;
      press(mask, $urandom_range(1, 10), $urandom_range(1, 10));
    end
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a lockout
    do_reset();
    repeat (3) press(ENTER, 8, 8);
    wait_alarm(1'b1, "t7_reach_lockout");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_big_bin", bus.big_bin, 20'h00000);
    check("t7_rst_cursor", bus.cursor, 2'd3);
    check("t7_rst_unlocked", bus.unlocked, 1'b0);
    check("t7_rst_alarm", bus.alarm, 1'b0);
    check("t7_rst_fail_count", bus.fail_count, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
